stream_mux_n: RTL and testbench
===============================

STREAM_MUX_N -- requirements
Module: stream_mux_n

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width per channel.
REQ-002 SHALL have parameter N, default 4, input channel count (2..256).
REQ-003 SHALL have parameter SEL_W, default 8, select/channel-index width.
REQ-004 SHALL have parameter PKT_LEN, default 16, beats per packet (>=1).
REQ-005 SHALL have parameter MODE, default 0: 0 = explicit select, 1 = round-robin.
REQ-006 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have sel  input  SEL_W  requested channel (MODE 0 only).
REQ-009 SHALL have in_data  input  N*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have in_valid  input  N  per-channel valid.
REQ-011 SHALL have in_ready  output  N  per-channel ready.
REQ-012 SHALL have out_data  output  WIDTH  registered output beat.
REQ-013 SHALL have out_valid  output  1  out_data holds an unconsumed beat.
REQ-014 SHALL have out_ready  input  1  downstream accepts beat.
REQ-015 SHALL have busy  output  1  high while a packet is locked (state XFER).
REQ-016 SHALL have cur_ch  output  SEL_W  currently or last locked channel.
REQ-017 SHALL have err_sel  output  1  sticky flag: out-of-range select seen.

Function
REQ-018 SHALL implement FSM states IDLE and XFER.
REQ-019 In IDLE, MODE 0: sel < N SHALL lock cur_ch = sel and move to XFER next cycle; sel >= N SHALL set err_sel, stay IDLE, lock nothing.
REQ-020 In IDLE, MODE 1: SHALL lock the first channel with in_valid high, searching upward from (last granted + 1) mod N with wrap-around; none valid -> stay IDLE.
REQ-021 In IDLE, all in_ready bits SHALL be 0 (lock cycle; no beat accepted).
REQ-022 In XFER, in_ready[cur_ch] SHALL equal (!out_valid || out_ready); all other in_ready bits 0.
REQ-023 Beat accepted when in_valid[cur_ch] && in_ready[cur_ch]; out_data SHALL load that channel's data next edge, out_valid set (latency 1 cycle).
REQ-024 out_valid SHALL clear when out_ready is high and no beat is accepted in that cycle; out_data SHALL hold while out_valid && !out_ready.
REQ-025 Simultaneous output drain and new accept SHALL keep out_valid high with the new data (full throughput, 1 beat/cycle).
REQ-026 Beat counter SHALL count accepted beats 0..PKT_LEN-1; on acceptance of beat PKT_LEN-1, counter SHALL wrap to 0 and FSM SHALL return to IDLE.
REQ-027 Changes on sel or other channels' in_valid during XFER SHALL be ignored until packet end.
REQ-028 err_sel SHALL remain 1 until reset; it does not block later valid selects.
REQ-029 Minimum gap between packets SHALL be one IDLE cycle; the output register may still drain during it.

Reset
REQ-030 On rst_n low, immediately and independent of clk: state IDLE, out_data 0, out_valid 0, in_ready all 0, busy 0, cur_ch 0, err_sel 0, beat counter 0, round-robin last-grant pointer N-1 (first grant is channel 0).
REQ-031 Reset asserted mid-packet SHALL discard the packet and the buffered beat; no output after release until a new lock.

Verification
REQ-032 MODE 0, N=4, PKT_LEN=4, sel=2, ch2 valid with data 0x0A..0x0D, out_ready=1 -> busy high next cycle, out_data 0x0A..0x0D on 4 consecutive cycles, one cycle after each accept, then IDLE.
REQ-033 MODE 0, sel=5 (>=N) -> err_sel=1, busy stays 0, in_ready=0000; then sel=1 -> packet from ch1 transfers, err_sel still 1.
REQ-034 Backpressure: out_ready=0 for 3 cycles mid-packet -> out_data stable, in_ready[cur_ch]=0, no beat lost or duplicated, count resumes.
REQ-035 MODE 1, channels 0,1,3 valid continuously -> grant order 0,1,3,0,... with one IDLE cycle between packets.
REQ-036 rst_n pulsed low during beat 2 of a packet -> all outputs zero asynchronously; after release, sel=0 starts a fresh full PKT_LEN packet.
REQ-037 sel switched from 2 to 0 mid-packet -> remaining beats still from ch2; ch0 served only after packet end.

Source files
------------

// File: rtl/stream_mux_n.sv
// N-to-1 packet stream multiplexer. A channel is locked for PKT_LEN beats, either by
// explicit select or round-robin, and its beats pass through a single output register.
module stream_mux_n #(
    parameter int WIDTH   = 16,
    parameter int N       = 4,
    parameter int SEL_W   = 8,
    parameter int PKT_LEN = 16,
    parameter int MODE    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [SEL_W-1:0]     cur_ch,
    output logic                 err_sel
);

    localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   cur_ch_q, cur_ch_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic               err_sel_q, err_sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;

    logic [N-1:0]       in_ready_s;
    logic [WIDTH-1:0]   ch_data_s;
    logic               ch_valid_s;
    logic               slot_free_s;
    logic               accept_s;
    logic [SEL_W:0]     rr_pick_s;

    // Round-robin search: MSB = found, low bits = first valid channel after 'last'.
    function automatic logic [SEL_W:0] rr_pick(input logic [SEL_W-1:0] last,
                                               input logic [N-1:0]     valid);
        logic [SEL_W:0] res;
        res = '0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (int'(last) + 1 + i) % N;
            res = (!res[SEL_W] && valid[idx]) ? {1'b1, SEL_W'(idx)} : res;
        end
        return res;
    endfunction

    // Data/valid of the currently locked channel.
    always_comb begin
        ch_data_s  = '0;
        ch_valid_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            ch_data_s  = (cur_ch_q == SEL_W'(k)) ? in_data[k*WIDTH +: WIDTH] : ch_data_s;
            ch_valid_s = (cur_ch_q == SEL_W'(k)) ? in_valid[k] : ch_valid_s;
        end
    end

    // Next-state logic for lock FSM, beat counter and output register.
    always_comb begin
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        last_d      = last_q;
        err_sel_d   = err_sel_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_s  = '0;
        rr_pick_s   = rr_pick(last_q, in_valid);
        slot_free_s = !out_valid_q || out_ready;
        accept_s    = (state_q == XFER) && ch_valid_s && slot_free_s;

        case (state_q)
            IDLE: begin
                if (MODE == 0) begin
                    if (int'(sel) < N) begin
                        cur_ch_d = sel;
                        last_d   = sel;
                        state_d  = XFER;
                    end else begin
                        err_sel_d = 1'b1;
                    end
                end else begin
                    if (rr_pick_s[SEL_W]) begin
                        cur_ch_d = rr_pick_s[SEL_W-1:0];
                        last_d   = rr_pick_s[SEL_W-1:0];
                        state_d  = XFER;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            XFER: begin
                for (int k = 0; k < N; k++) begin
                    in_ready_s[k] = (cur_ch_q == SEL_W'(k)) && slot_free_s;
                end
                if (accept_s) begin
                    if (cnt_q == CNT_W'(PKT_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output register: load on accept, otherwise drain when downstream takes it.
        if (accept_s) begin
            out_data_d  = ch_data_s;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; the round-robin pointer resets to N-1 so channel 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_ch_q    <= '0;
            last_q      <= SEL_W'(N - 1);
            err_sel_q   <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            last_q      <= last_d;
            err_sel_q   <= err_sel_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == XFER);
    assign cur_ch    = cur_ch_q;
    assign err_sel   = err_sel_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Scoreboard bench for stream_mux_n: explicit-select and round-robin instances driven
// by directed sequences; a monitor pops expected beats as the outputs are consumed.
module tb_stream_mux_n;

    localparam logic [15:0] BASE [4] = '{16'h0100, 16'h1100, 16'h000A, 16'h3300};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  sel0, sel1;
    logic [63:0] in_data0, in_data1;
    logic [3:0]  in_valid0, in_valid1, in_ready0, in_ready1;
    logic [15:0] out_data0, out_data1;
    logic        out_valid0, out_valid1, out_ready0, out_ready1;
    logic        busy0, busy1, err_sel0, err_sel1;
    logic [7:0]  cur_ch0, cur_ch1;

    int          cnt0 [4] = '{0, 0, 0, 0};
    int          cnt1 [4] = '{0, 0, 0, 0};
    logic [3:0]  acc0 = 4'b0000;
    logic [3:0]  acc1 = 4'b0000;
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    stream_mux_n #(.WIDTH(16), .N(4), .SEL_W(8), .PKT_LEN(4), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sel(sel0), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(out_ready0), .busy(busy0), .cur_ch(cur_ch0), .err_sel(err_sel0));

    stream_mux_n #(.WIDTH(16), .N(4), .SEL_W(8), .PKT_LEN(4), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sel(sel1), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .busy(busy1), .cur_ch(cur_ch1), .err_sel(err_sel1));

    // Each source presents BASE[k] + number of beats already accepted from it.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            in_data0[k*16 +: 16] = BASE[k] + 16'(cnt0[k]);
            in_data1[k*16 +: 16] = BASE[k] + 16'(cnt1[k]);
        end
    end

    // Handshake sampled mid-cycle, applied to the source counters after the edge.
    always @(negedge clk) begin
        acc0 = in_valid0 & in_ready0;
        acc1 = in_valid1 & in_ready1;
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 4; k++) begin
            if (acc0[k]) cnt0[k] = cnt0[k] + 1;
            if (acc1[k]) cnt1[k] = cnt1[k] + 1;
        end
    end

    // Monitor: every consumed output beat must match the head of its queue.
    always @(negedge clk) begin
        logic [15:0] e;
        if (out_valid0 && out_ready0) begin
            n_chk = n_chk + 1;
            if (q0.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL out0_extra got %0h expected no beat", out_data0);
            end else begin
                e = q0.pop_front();
                if (out_data0 !== e) begin
                    n_fail = n_fail + 1;
                    $display("FAIL out0_beat got %0h expected %0h", out_data0, e);
                end
            end
        end
        if (out_valid1 && out_ready1) begin
            n_chk = n_chk + 1;
            if (q1.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL out1_extra got %0h expected no beat", out_data1);
            end else begin
                e = q1.pop_front();
                if (out_data1 !== e) begin
                    n_fail = n_fail + 1;
                    $display("FAIL out1_beat got %0h expected %0h", out_data1, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push0(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) q0.push_back(first + 16'(i));
    endtask

    task automatic push1(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) q1.push_back(first + 16'(i));
    endtask

    task automatic wait_cnt0(input int ch, input int target);
        int guard = 0;
        while (cnt0[ch] < target && guard < 200) begin
            step();
            guard++;
        end
        chk($sformatf("wait_cnt0_ch%0d", ch), cnt0[ch], target);
    endtask

    task automatic wait_cnt1(input int ch, input int target);
        int guard = 0;
        while (cnt1[ch] < target && guard < 200) begin
            step();
            guard++;
        end
        chk($sformatf("wait_cnt1_ch%0d", ch), cnt1[ch], target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [4] = '{0, 1, 3, 0};
        int tgt   [4] = '{4, 4, 4, 8};
        int guard;

        rst_n = 1'b0; sel0 = 8'd2; sel1 = 8'd0;
        in_valid0 = 4'b0000; in_valid1 = 4'b0000;
        out_ready0 = 1'b1; out_ready1 = 1'b1;
        repeat (2) step();
        chk("rst_out_valid", out_valid0, 1'b0);
        chk("rst_out_data", out_data0, 16'h0000);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_cur_ch", cur_ch0, 8'd0);
        chk("rst_err_sel", err_sel0, 1'b0);
        chk("rst_in_ready", in_ready0, 4'b0000);
        chk("rst_in_ready_rr", in_ready1, 4'b0000);

        // Explicit select of channel 2, one full packet.
        in_valid0 = 4'b0100;
        push0(16'h000A, 4);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", in_ready0, 4'b0000);
        step();
        chk("lock_busy", busy0, 1'b1);
        chk("lock_cur_ch", cur_ch0, 8'd2);
        chk("lock_in_ready", in_ready0, 4'b0100);
        wait_cnt0(2, 4);
        chk("pkt_end_idle", busy0, 1'b0);

        // Out-of-range select, then a valid select of channel 1 with backpressure.
        sel0 = 8'd5; in_valid0 = 4'b0000;
        step();
        chk("bad_sel_err", err_sel0, 1'b1);
        chk("bad_sel_busy", busy0, 1'b0);
        chk("bad_sel_in_ready", in_ready0, 4'b0000);
        sel0 = 8'd1; in_valid0 = 4'b0010;
        push0(16'h1100, 4);
        wait_cnt0(1, 2);
        out_ready0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_out_data", out_data0, 16'h1101);
            chk("bp_out_valid", out_valid0, 1'b1);
            chk("bp_in_ready", in_ready0, 4'b0000);
            chk("bp_count", cnt0[1], 2);
            step();
        end
        out_ready0 = 1'b1;
        wait_cnt0(1, 4);
        chk("err_sticky", err_sel0, 1'b1);

        // Switch select mid-packet: channel 2 keeps the lock until its packet ends.
        sel0 = 8'd2; in_valid0 = 4'b0101;
        push0(16'h000E, 4);
        push0(16'h0100, 2);
        wait_cnt0(2, 5);
        sel0 = 8'd0;
        wait_cnt0(2, 8);
        chk("switch_ch0_waits", cnt0[0], 0);
        chk("switch_gap_idle", busy0, 1'b0);
        step();
        in_valid0 = 4'b0001;
        chk("switch_busy", busy0, 1'b1);
        chk("switch_cur_ch", cur_ch0, 8'd0);

        // Reset while beat 2 of the channel-0 packet sits in the output register.
        guard = 0;
        while (q0.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #2;
        chk("pre_reset_drained", q0.size(), 0);
        chk("pre_reset_count", cnt0[0], 3);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid0, 1'b0);
        chk("arst_out_data", out_data0, 16'h0000);
        chk("arst_busy", busy0, 1'b0);
        chk("arst_in_ready", in_ready0, 4'b0000);
        chk("arst_cur_ch", cur_ch0, 8'd0);
        chk("arst_err_sel", err_sel0, 1'b0);
        step();
        push0(16'h0103, 4);
        rst_n = 1'b1;
        wait_cnt0(0, 7);
        in_valid0 = 4'b0000;

        // Round-robin over channels 0, 1, 3.
        in_valid1 = 4'b1011;
        push1(16'h0100, 4);
        push1(16'h1100, 4);
        push1(16'h3300, 4);
        push1(16'h0104, 4);
        for (int g = 0; g < 4; g++) begin
            guard = 0;
            while (!busy1 && guard < 50) begin
                step();
                guard++;
            end
            chk($sformatf("rr_grant%0d_ch", g), cur_ch1, 8'(order[g]));
            wait_cnt1(order[g], tgt[g]);
            chk($sformatf("rr_gap%0d", g), busy1, 1'b0);
            if (g < 3) begin
                step();
                chk($sformatf("rr_relock%0d", g), busy1, 1'b1);
            end
        end
        in_valid1 = 4'b0000;

        repeat (5) step();
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("rr_idle_end", busy1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
